// File: rtl/mult_div_unit_if.sv
// Request/result bundle for the multiply/divide unit.
// The master side drives the operands and the MTHI/MTLO writes; the slave side returns HI/LO and status.
`timescale 1ns/1ps
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_rs;
  logic [WIDTH-1:0] data_rt;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, data_rs, data_rt, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, data_rs, data_rt, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Signed operations run on magnitudes; the sign is fixed up on the last iteration.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;
  logic             busy_c, done_c;

  // operation context captured on start
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               neg_q, rneg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q, quo_q;

  logic               accept, div_zero;
  logic [WIDTH-1:0]   mag_rs, mag_rt;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_nxt, prod_fix;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, res_hi, res_lo;

  function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + ONE_W) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dword(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + ONE_2W) : x;
  endfunction

  assign accept   = bus.start && (state_q != CALC);
  assign div_zero = bus.op[1] && (bus.data_rt == '0);
  assign mag_rs   = neg_word(bus.data_rs, bus.op[0] & bus.data_rs[WIDTH-1]);
  assign mag_rt   = neg_word(bus.data_rt, bus.op[0] & bus.data_rt[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) state_d = div_zero ? DONE : CALC;
      CALC: begin
        busy_c = 1'b1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = bus.start ? (div_zero ? DONE : CALC) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // one shift-add step and one restoring-divide step, plus the final sign fix-up
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    rem_nxt   = div_diff[WIDTH-1:0];
    quo_nxt   = {quo_q[WIDTH-2:0], 1'b1};
    if (div_diff[WIDTH]) begin
      rem_nxt = div_shift[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
    prod_fix = neg_dword(acc_nxt, op_q[0] & neg_q);
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      res_hi = neg_word(rem_nxt, op_q[0] & rneg_q);
      res_lo = neg_word(quo_nxt, op_q[0] & neg_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        dbz_q <= div_zero;
        if (div_zero) begin
          hi_q <= bus.data_rs;
          lo_q <= '1;
        end
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  // datapath registers carry no reset; control state alone decides when they matter
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.op;
      a_q    <= mag_rs;
      b_q    <= mag_rt;
      neg_q  <= bus.op[0] & (bus.data_rs[WIDTH-1] ^ bus.data_rt[WIDTH-1]);
      rneg_q <= bus.op[0] & bus.data_rs[WIDTH-1];
      acc_q  <= {{WIDTH{1'b0}}, mag_rt};
      rem_q  <= '0;
      quo_q  <= mag_rs;
    end else if (state_q == CALC) begin
      acc_q <= acc_nxt;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases followed by randomized operations
// compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] m_hi, m_lo;
  logic         m_dz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic, SV division truncates toward zero
  task automatic model(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = {32'b0, rs} * {32'b0, rt}; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'd2: begin
        if (rt == 0) begin dz = 1'b1; hi = rs; lo = '1; end
        else begin lo = rs / rt; hi = rs % rt; end
      end
      default: begin
        if (rt == 0) begin dz = 1'b1; hi = rs; lo = '1; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
    endcase
  endtask

  // called at a negedge; returns at the negedge inside the DONE cycle
  task automatic run(input logic [1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                     input logic wr_hi);
    logic [W-1:0] eh, el, prev_hi;
    logic edz;
    int cyc, bcnt;
    model(op, rs, rt, eh, el, edz);
    prev_hi       = m_hi;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.data_rs   = rs;
    bus.data_rt   = rt;
    bus.hi_we     = wr_hi;
    bus.wdata     = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.hi_we     = 1'b0;
    bus.op        = 2'($urandom);
    bus.data_rs   = $urandom;
    bus.data_rt   = $urandom;
    chk("dbz_on_accept", bus.div_by_zero, edz);
    if (!edz) chk("hi_held_in_calc", bus.hi, prev_hi);
    cyc  = 0;
    bcnt = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, edz ? 0 : 32);
    chk("busy_cycles", bcnt, edz ? 0 : 32);
    chk("hi", bus.hi, eh);
    chk("lo", bus.lo, el);
    chk("dbz", bus.div_by_zero, edz);
    m_hi = eh;
    m_lo = el;
    m_dz = edz;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    logic [W-1:0] w;
    logic [1:0]   rop;
    logic [W-1:0] rrs, rrt;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.data_rs = '0; bus.data_rt = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    run(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_lit", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo_lit", bus.lo, 32'h0000_0001);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);

    run(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    chk("mult_lo_lit", bus.lo, 32'hFFFF_FFEB);
    @(negedge clk);
    run(2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_lo_lit", bus.lo, 32'hFFFF_FFFD);
    run(2'd2, 32'd100, 32'd7, 1'b0);
    chk("divu_b2b_lo_lit", bus.lo, 32'd14);
    chk("divu_b2b_hi_lit", bus.hi, 32'd2);
    run(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_lit", bus.lo, 32'h8000_0000);
    run(2'd2, 32'd5, 32'd0, 1'b0);
    chk("dz_lo_lit", bus.lo, 32'hFFFF_FFFF);
    run(2'd0, 32'd3, 32'd5, 1'b1);

    // MTHI preload, then a MULTU that is hammered during CALC and aborted by reset
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi", bus.hi, 32'h1234_5678);
    bus.start = 1'b1; bus.op = 2'd0; bus.data_rs = $urandom; bus.data_rt = $urandom;
    @(negedge clk);
    bus.op = 2'd2; bus.data_rt = '0; bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("hi_we_in_calc", bus.hi, 32'h1234_5678);
    chk("busy_in_calc", bus.busy, 1);
    chk("start_in_calc_dbz", bus.div_by_zero, 0);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("no_done_after_abort", dcnt, 0);
    w = $urandom;
    bus.lo_we = 1'b1; bus.wdata = w;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo", bus.lo, w);
    chk("mtlo_hi_untouched", bus.hi, 0);
    m_lo = w;

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rrs = $urandom;
      rrt = $urandom;
      case ($urandom_range(0, 7))
        0: rrt = '0;
        1: rrt = 32'($urandom_range(1, 15));
        2: rrs = 32'h8000_0000;
        3: rrt = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom;
        bus.lo_we = 1'b1; bus.wdata = w;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_rand", bus.lo, w);
        m_lo = w;
      end
      run(rop, rrs, rrt, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
